lmfe_param: RTL

LMFE_PARAM -- requirements
Module: lmfe_param

---
 rtl/lmfe_pkg.sv | 33 +++
 rtl/lmfe_bitsel.sv | 68 ++++++
 rtl/lmfe_param.sv | 201 ++++++++++++++++++++
 3 files changed

// File: rtl/lmfe_pkg.sv
// Shared FSM encoding and size helpers for the local median filter engine.
package lmfe_pkg;

   typedef enum logic [2:0] {
      IDLE,
      LOAD,
      SEL,
      OUT,
      DRAIN
   } lmfe_state_t;

   // Bits needed to hold the values 0..value-1 (never less than 1).
   function automatic int unsigned lmfe_log2(input int unsigned value);
      int unsigned bits;
      bits = 1;
      for (int unsigned span = 2; span < value; span = span * 2) bits++;
      return bits;
   endfunction

   function automatic int unsigned lmfe_win_cnt(input int unsigned ksize);
      return ksize * ksize;
   endfunction

   function automatic int unsigned lmfe_rank_m(input int unsigned ksize);
      return (ksize * ksize + 1) / 2;
   endfunction

   function automatic int unsigned lmfe_buf_depth(input int unsigned ksize,
                                                  input int unsigned img_w);
      return ksize * img_w;
   endfunction

endpackage

// File: rtl/lmfe_bitsel.sv
// Bit-serial rank selector: finds the RANK-th smallest of NWIN values, one bit per step, MSB first.
module lmfe_bitsel
   import lmfe_pkg::*;
#(
   parameter int unsigned DATA_W = 8,
   parameter int unsigned NWIN   = 49,
   parameter int unsigned RANK   = 25
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         load,
   input  logic                         step,
   input  logic [NWIN-1:0][DATA_W-1:0]  vals,
   output logic [DATA_W-1:0]            result,
   output logic                         last_c
);

   localparam int unsigned CNT_W = lmfe_log2(NWIN + 1);
   localparam int unsigned BIT_W = lmfe_log2(DATA_W);

   logic [NWIN-1:0][DATA_W-1:0] cand;
   logic [NWIN-1:0]             active;
   logic [NWIN-1:0]             ones_c;
   logic [CNT_W-1:0]            rank;
   logic [CNT_W-1:0]            cnt0_c;
   logic [BIT_W-1:0]            bit_idx;

   // Zeros among still-active candidates at the bit under test.
   always_comb begin
      ones_c = '0;
      cnt0_c = '0;
      for (int k = 0; k < NWIN; k++) begin
         ones_c[k] = cand[k][bit_idx];
         if (active[k] && !ones_c[k]) cnt0_c = cnt0_c + CNT_W'(1);
      end
   end

   assign last_c = (bit_idx == '0);

   always_ff @(posedge clk) begin
      if (load) cand <= vals;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         active  <= '0;
         rank    <= '0;
         bit_idx <= '0;
         result  <= '0;
      end else if (load) begin
         active  <= '1;
         rank    <= CNT_W'(RANK);
         bit_idx <= BIT_W'(DATA_W - 1);
         result  <= '0;
      end else if (step) begin
         if (rank <= cnt0_c) begin
            result[bit_idx] <= 1'b0;
            active          <= active & ~ones_c;
         end else begin
            result[bit_idx] <= 1'b1;
            rank            <= rank - cnt0_c;
            active          <= active & ones_c;
         end
         bit_idx <= bit_idx - BIT_W'(1);
      end
   end

endmodule

// File: rtl/lmfe_param.sv
// Streaming KSIZE x KSIZE zero-padded median filter over a raster image.
// Optional frame_done strobe enabled by defining LMFE_FRAME_DONE_EN.
module lmfe_param
   import lmfe_pkg::*;
#(
   parameter int unsigned DATA_W = 8,
   parameter int unsigned IMG_W  = 128,
   parameter int unsigned IMG_H  = 128,
   parameter int unsigned KSIZE  = 7
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [DATA_W-1:0] Din,
   input  logic              in_en,
   output logic              busy,
   output logic              out_valid,
   output logic [DATA_W-1:0] Dout
`ifdef LMFE_FRAME_DONE_EN
   ,
   output logic              frame_done
`endif
);

   localparam int unsigned N      = IMG_W * IMG_H;
   localparam int unsigned HALF   = (KSIZE - 1) / 2;
   localparam int unsigned NWIN   = lmfe_win_cnt(KSIZE);
   localparam int unsigned RANK   = lmfe_rank_m(KSIZE);
   localparam int unsigned DEPTH  = lmfe_buf_depth(KSIZE, IMG_W);
   localparam int unsigned CNT_W  = lmfe_log2(N + 1);
   localparam int unsigned CNT1_W = CNT_W + 1;
   localparam int unsigned ADDR_W = lmfe_log2(DEPTH);
   localparam int unsigned COL_W  = lmfe_log2(IMG_W);
   localparam int unsigned ROW_W  = lmfe_log2(IMG_H);
   localparam int unsigned SLOT_W = lmfe_log2(KSIZE);
   localparam int unsigned LEAD   = HALF * IMG_W + HALF + 1;
   localparam int          KS     = int'(KSIZE);
   localparam int          HS     = int'(HALF);
   localparam int          WS     = int'(IMG_W);
   localparam int          HGT    = int'(IMG_H);

   lmfe_state_t state;

   logic [DATA_W-1:0]            mem [DEPTH];
   logic [CNT_W-1:0]             acc_cnt;
   logic [CNT_W-1:0]             out_cnt;
   logic [COL_W-1:0]             wr_col;
   logic [SLOT_W-1:0]            wr_slot;
   logic [COL_W-1:0]             out_c;
   logic [ROW_W-1:0]             out_r;
   logic [SLOT_W-1:0]            out_slot;

   logic                         accept_c;
   logic                         trigger_c;
   logic                         out_last_c;
   logic [CNT_W-1:0]             acc_nxt_c;
   logic [CNT1_W-1:0]            thr_sum_c;
   logic [CNT1_W-1:0]            thr_c;
   logic [ADDR_W-1:0]            wr_addr_c;
   logic [NWIN-1:0][DATA_W-1:0]  win_c;
   logic [DATA_W-1:0]            sel_result;
   logic                         sel_last_c;

   assign accept_c   = in_en && (state == IDLE);
   assign acc_nxt_c  = acc_cnt + CNT_W'(1);
   assign thr_sum_c  = {1'b0, out_cnt} + CNT1_W'(LEAD);
   assign thr_c      = (thr_sum_c > CNT1_W'(N)) ? CNT1_W'(N) : thr_sum_c;
   assign trigger_c  = accept_c && ({1'b0, acc_nxt_c} >= thr_c);
   assign out_last_c = (out_cnt == CNT_W'(N - 1));
   assign wr_addr_c  = ADDR_W'(wr_slot * IMG_W + wr_col);

   always_ff @(posedge clk) begin
      if (accept_c) mem[wr_addr_c] <= Din;
   end

   // Gather the window around (out_r, out_c); positions outside the image read as zero.
   always_comb begin
      int rr;
      int cc;
      int slot;
      rr    = 0;
      cc    = 0;
      slot  = 0;
      win_c = '0;
      for (int i = 0; i < KS; i++) begin
         for (int j = 0; j < KS; j++) begin
            rr   = int'(out_r) + i - HS;
            cc   = int'(out_c) + j - HS;
            slot = int'(out_slot) + i + KS - HS;
            if (slot >= KS) slot = slot - KS;
            if (slot >= KS) slot = slot - KS;
            if (rr >= 0 && rr < HGT && cc >= 0 && cc < WS)
               win_c[i*KS + j] = mem[ADDR_W'(slot * WS + cc)];
         end
      end
   end

   lmfe_bitsel #(
      .DATA_W (DATA_W),
      .NWIN   (NWIN),
      .RANK   (RANK)
   ) u_bitsel (
      .clk    (clk),
      .reset  (reset),
      .load   (state == LOAD),
      .step   (state == SEL),
      .vals   (win_c),
      .result (sel_result),
      .last_c (sel_last_c)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= IDLE;
         busy      <= 1'b0;
         out_valid <= 1'b0;
         Dout      <= '0;
         acc_cnt   <= '0;
         out_cnt   <= '0;
         wr_col    <= '0;
         wr_slot   <= '0;
         out_c     <= '0;
         out_r     <= '0;
         out_slot  <= '0;
      end else begin
         out_valid <= 1'b0;
         if (accept_c) begin
            acc_cnt <= acc_nxt_c;
            if (wr_col == COL_W'(IMG_W - 1)) begin
               wr_col  <= '0;
               wr_slot <= (wr_slot == SLOT_W'(KSIZE - 1)) ? '0 : wr_slot + SLOT_W'(1);
            end else begin
               wr_col <= wr_col + COL_W'(1);
            end
         end
         case (state)
            IDLE: begin
               if (trigger_c) begin
                  state <= LOAD;
                  busy  <= 1'b1;
               end
            end
            LOAD: state <= SEL;
            SEL: begin
               if (sel_last_c) state <= OUT;
            end
            OUT: begin
               out_valid <= 1'b1;
               Dout      <= sel_result;
               if (out_last_c) begin
                  // Frame complete: rewind everything for the next frame.
                  state    <= IDLE;
                  busy     <= 1'b0;
                  acc_cnt  <= '0;
                  out_cnt  <= '0;
                  wr_col   <= '0;
                  wr_slot  <= '0;
                  out_c    <= '0;
                  out_r    <= '0;
                  out_slot <= '0;
               end else begin
                  out_cnt <= out_cnt + CNT_W'(1);
                  if (out_c == COL_W'(IMG_W - 1)) begin
                     out_c    <= '0;
                     out_r    <= out_r + ROW_W'(1);
                     out_slot <= (out_slot == SLOT_W'(KSIZE - 1)) ? '0 : out_slot + SLOT_W'(1);
                  end else begin
                     out_c <= out_c + COL_W'(1);
                  end
                  if (acc_cnt < CNT_W'(N)) begin
                     state <= IDLE;
                     busy  <= 1'b0;
                  end else begin
                     state <= DRAIN;
                  end
               end
            end
            DRAIN:   state <= LOAD;
            default: begin
               state <= IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end

`ifdef LMFE_FRAME_DONE_EN
   logic last_strobe;

   // Trails the out_valid of the final pixel by one cycle.
   always_ff @(posedge clk) begin
      if (reset) begin
         last_strobe <= 1'b0;
         frame_done  <= 1'b0;
      end else begin
         last_strobe <= (state == OUT) && out_last_c;
         frame_done  <= last_strobe;
      end
   end
`endif

endmodule
